// File: rtl/rs485_loopback_sequencer.sv
// Loopback test sequencer: frames TX pattern bursts, checks each returned bit
// against the delayed TX bit, and keeps sticky per-channel and total error results.
module rs485_loopback_sequencer #(
    parameter int NCH      = 11,
    parameter int LOOP_DLY = 2,
    parameter int GAP_CYC  = 4
) (
    input  logic           data_clk,
    input  logic           OPB_RST,
    input  logic           start_i,
    input  logic           freerun_i,
    input  logic [7:0]     frame_len_i,
    input  logic [7:0]     repeat_cnt_i,
    input  logic [NCH-1:0] exp_bits_i,
    input  logic [NCH-1:0] rx_bits_i,
    output logic           load_pattern_o,
    output logic           clock_en_o,
    output logic           shift_en_o,
    output logic           capture_en_o,
    output logic [8:0]     bit_count_o,
    output logic [7:0]     frame_idx_o,
    output logic           busy_o,
    output logic           done_o,
    output logic [NCH-1:0] err_mask_o,
    output logic [15:0]    err_total_o,
    output logic [2:0]     state_o
);

    localparam int PW = $clog2(NCH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q;
    logic [8:0]     bit_count_q, bit_count_d;
    logic [7:0]     frame_idx_q, frame_idx_d;
    logic [NCH-1:0] err_mask_q, err_mask_d;
    logic [15:0]    err_total_q, err_total_d;

    logic [8:0]     frame_bits;
    logic           run_last, drain_last, gap_last, more_frames, active, check_en;
    logic [NCH-1:0] exp_dly, mismatch;
    logic           vld_dly;
    logic [PW-1:0]  mm_cnt;
    logic [16:0]    err_sum;

    function automatic logic [PW-1:0] popcount(input logic [NCH-1:0] v);
        popcount = '0;
        for (int i = 0; i < NCH; i++) popcount = popcount + PW'(v[i]);
    endfunction

    // A frame_len of 0 encodes a full 256-bit frame.
    assign frame_bits  = (frame_len_i == 8'd0) ? 9'd256 : {1'b0, frame_len_i};
    assign run_last    = (bit_count_q == frame_bits - 9'd1);
    assign drain_last  = (cnt_q == 8'(LOOP_DLY - 1));
    assign gap_last    = (cnt_q == 8'(GAP_CYC - 1));
    assign more_frames = freerun_i || (frame_idx_q < repeat_cnt_i);
    assign active      = (state_q == S_LOAD) || (state_q == S_RUN) ||
                         (state_q == S_DRAIN) || (state_q == S_GAP);
    assign check_en    = (state_q == S_RUN) || (state_q == S_DRAIN);

    always_ff @(posedge data_clk or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_LOAD;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   if (run_last) state_d = (LOOP_DLY > 0) ? S_DRAIN :
                                             (more_frames ? S_GAP : S_DONE);
            S_DRAIN: if (drain_last) state_d = more_frames ? S_GAP : S_DONE;
            S_GAP:   if (gap_last) state_d = S_LOAD;
            S_DONE:  if (!start_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (active && !start_i) state_d = S_IDLE;
    end

    always_comb begin
        load_pattern_o = 1'b0;
        clock_en_o     = 1'b0;
        shift_en_o     = 1'b0;
        capture_en_o   = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        unique case (state_q)
            S_LOAD:  begin load_pattern_o = 1'b1; busy_o = 1'b1; end
            S_RUN:   begin clock_en_o = 1'b1; shift_en_o = 1'b1; capture_en_o = 1'b1; busy_o = 1'b1; end
            S_DRAIN: begin clock_en_o = 1'b1; capture_en_o = 1'b1; busy_o = 1'b1; end
            S_GAP:   busy_o = 1'b1;
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    // Phase counter for DRAIN and GAP; restarts on every state change.
    always_ff @(posedge data_clk or posedge OPB_RST) begin
        if (OPB_RST) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    if (LOOP_DLY == 0) begin : g_nodly
        assign exp_dly = exp_bits_i;
        assign vld_dly = shift_en_o;
    end else begin : g_dly
        logic [NCH-1:0]      exp_pipe_q [LOOP_DLY];
        logic [LOOP_DLY-1:0] vld_pipe_q;

        always_ff @(posedge data_clk or posedge OPB_RST) begin
            if (OPB_RST || state_q == S_LOAD) begin
                vld_pipe_q <= '0;
                for (int i = 0; i < LOOP_DLY; i++) exp_pipe_q[i] <= '0;
            end else begin
                exp_pipe_q[0] <= exp_bits_i;
                vld_pipe_q[0] <= shift_en_o;
                for (int i = 1; i < LOOP_DLY; i++) begin
                    exp_pipe_q[i] <= exp_pipe_q[i-1];
                    vld_pipe_q[i] <= vld_pipe_q[i-1];
                end
            end
        end

        assign exp_dly = exp_pipe_q[LOOP_DLY-1];
        assign vld_dly = vld_pipe_q[LOOP_DLY-1];
    end

    assign mismatch = {NCH{vld_dly}} & (exp_dly ^ rx_bits_i);
    assign mm_cnt   = popcount(mismatch);
    assign err_sum  = {1'b0, err_total_q} + 17'(mm_cnt);

    always_comb begin
        bit_count_d = bit_count_q;
        frame_idx_d = frame_idx_q;
        err_mask_d  = err_mask_q;
        err_total_d = err_total_q;
        unique case (state_q)
            S_IDLE: if (start_i) begin
                bit_count_d = '0;
                frame_idx_d = '0;
                err_mask_d  = '0;
                err_total_d = '0;
            end
            S_LOAD: bit_count_d = '0;
            S_RUN:  bit_count_d = bit_count_q + 9'd1;
            S_GAP:  if (gap_last) begin
                bit_count_d = '0;
                frame_idx_d = frame_idx_q + 8'd1;
            end
            default: ;
        endcase
        if (check_en) begin
            err_mask_d  = err_mask_q | mismatch;
            err_total_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    always_ff @(posedge data_clk or posedge OPB_RST) begin
        if (OPB_RST) begin
            bit_count_q <= '0;
            frame_idx_q <= '0;
            err_mask_q  <= '0;
            err_total_q <= '0;
        end else begin
            bit_count_q <= bit_count_d;
            frame_idx_q <= frame_idx_d;
            err_mask_q  <= err_mask_d;
            err_total_q <= err_total_d;
        end
    end

    assign bit_count_o = bit_count_q;
    assign frame_idx_o = frame_idx_q;
    assign err_mask_o  = err_mask_q;
    assign err_total_o = err_total_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_rs485_loopback_sequencer.sv
// Bench for rs485_loopback_sequencer: a frame-schedule model checks every cycle,
// directed scenarios pin strobe counts, error totals, abort and reset behaviour.
module tb_rs485_loopback_sequencer;

    localparam int NCH      = 11;
    localparam int LOOP_DLY = 2;
    localparam int GAP_CYC  = 4;

    // ---------------- clock / reset ----------------
    logic data_clk = 1'b0;
    logic OPB_RST  = 1'b1;
    always #5 data_clk = ~data_clk;

    logic           start      = 1'b0;
    logic           freerun    = 1'b0;
    logic [7:0]     frame_len  = 8'd8;
    logic [7:0]     repeat_cnt = 8'd0;
    logic [NCH-1:0] exp_bits   = '0;
    logic [NCH-1:0] rx_bits    = '0;
    logic [NCH-1:0] inv_mask   = '0;

    logic           load_pattern_o, clock_en_o, shift_en_o, capture_en_o;
    logic [8:0]     bit_count_o;
    logic [7:0]     frame_idx_o;
    logic           busy_o, done_o;
    logic [NCH-1:0] err_mask_o;
    logic [15:0]    err_total_o;
    logic [2:0]     state_o;

    rs485_loopback_sequencer #(.NCH(NCH), .LOOP_DLY(LOOP_DLY), .GAP_CYC(GAP_CYC)) dut (
        .data_clk       (data_clk),
        .OPB_RST        (OPB_RST),
        .start_i        (start),
        .freerun_i      (freerun),
        .frame_len_i    (frame_len),
        .repeat_cnt_i   (repeat_cnt),
        .exp_bits_i     (exp_bits),
        .rx_bits_i      (rx_bits),
        .load_pattern_o (load_pattern_o),
        .clock_en_o     (clock_en_o),
        .shift_en_o     (shift_en_o),
        .capture_en_o   (capture_en_o),
        .bit_count_o    (bit_count_o),
        .frame_idx_o    (frame_idx_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_mask_o     (err_mask_o),
        .err_total_o    (err_total_o),
        .state_o        (state_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expire(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
    endtask

    // ---------------- TX/RX channel driver ----------------
    // RX returns the TX bit from two cycles earlier, optionally inverted per channel.
    int unsigned    seed = 32'h1234_5678;
    logic [NCH-1:0] exp_prev1 = '0;
    logic [NCH-1:0] exp_prev2 = '0;
    always @(negedge data_clk) begin
        exp_prev2 = exp_prev1;
        exp_prev1 = exp_bits;
        seed      = seed * 32'd1664525 + 32'd1013904223;
        exp_bits  = seed[26:16];
        rx_bits   = exp_prev2 ^ inv_mask;
    end

    // ---------------- scoreboard / model ----------------
    // A run is a sequence of frames of period 1+L+LOOP_DLY+GAP_CYC; everything
    // follows from the offset inside that period.
    logic [NCH-1:0] exp_q[$];
    int             m_mode = 0;   // 0 idle, 1 running, 2 finished
    int             m_t = 0;
    int             m_bits = 0;
    int             m_fidx = 0;
    logic [NCH-1:0] m_err_mask = '0;
    int             m_err_total = 0;

    int cmp_cyc = 0;
    int cnt_load = 0, cnt_shift = 0, cnt_cap = 0;
    int lp_cyc[$];
    int lp_fidx[$];

    task automatic model_step();
        int L, P, o, f, nt, o2;
        logic [NCH-1:0] sent, mm;
        if (OPB_RST) begin
            m_mode = 0; m_t = 0; m_bits = 0; m_fidx = 0;
            m_err_mask = '0; m_err_total = 0;
            exp_q.delete();
            return;
        end
        L = (frame_len == 8'd0) ? 256 : int'(frame_len);
        P = 1 + L + LOOP_DLY + GAP_CYC;
        case (m_mode)
            0: if (start) begin
                m_mode = 1; m_t = 0; m_bits = 0; m_fidx = 0;
                m_err_mask = '0; m_err_total = 0;
            end
            1: begin
                o = m_t % P;
                f = m_t / P;
                if (o == 0) exp_q.delete();
                if (o >= 1 && o <= L) exp_q.push_back(exp_bits);
                if (o - LOOP_DLY >= 1 && o - LOOP_DLY <= L && exp_q.size() > 0) begin
                    sent = exp_q.pop_front();
                    mm = sent ^ rx_bits;
                    m_err_mask = m_err_mask | mm;
                    m_err_total = m_err_total + $countones(mm);
                    if (m_err_total > 65535) m_err_total = 65535;
                end
                nt = m_t + 1;
                o2 = nt % P;
                m_bits = (o2 == 0) ? 0 : ((o2 <= L) ? o2 - 1 : L);
                m_fidx = (nt / P) % 256;
                if (!start) m_mode = 0;
                else if (!freerun && f == int'(repeat_cnt) && o == L + LOOP_DLY) m_mode = 2;
                else m_t = nt;
            end
            2: if (!start) m_mode = 0;
            default: m_mode = 0;
        endcase
    endtask

    task automatic model_compare();
        int L, P, o;
        logic e_load, e_clk, e_shift, e_cap, e_busy, e_done;
        e_load = 0; e_clk = 0; e_shift = 0; e_cap = 0; e_busy = 0; e_done = 0;
        L = (frame_len == 8'd0) ? 256 : int'(frame_len);
        P = 1 + L + LOOP_DLY + GAP_CYC;
        if (m_mode == 1) begin
            o = m_t % P;
            e_busy  = 1;
            e_load  = (o == 0);
            e_shift = (o >= 1 && o <= L);
            e_clk   = (o >= 1 && o <= L + LOOP_DLY);
            e_cap   = e_clk;
        end
        if (m_mode == 2) e_done = 1;
        chk("load_pattern", 32'(load_pattern_o), 32'(e_load));
        chk("clock_en",     32'(clock_en_o),     32'(e_clk));
        chk("shift_en",     32'(shift_en_o),     32'(e_shift));
        chk("capture_en",   32'(capture_en_o),   32'(e_cap));
        chk("busy",         32'(busy_o),         32'(e_busy));
        chk("done",         32'(done_o),         32'(e_done));
        chk("bit_count",    32'(bit_count_o),    32'(m_bits));
        chk("frame_idx",    32'(frame_idx_o),    32'(m_fidx));
        chk("err_mask",     32'(err_mask_o),     32'(m_err_mask));
        chk("err_total",    32'(err_total_o),    32'(m_err_total));
    endtask

    always @(posedge data_clk) begin
        model_step();
        #1;
        model_compare();
        cmp_cyc++;
        if (load_pattern_o) begin
            cnt_load++;
            lp_cyc.push_back(cmp_cyc);
            lp_fidx.push_back(int'(frame_idx_o));
        end
        if (shift_en_o) cnt_shift++;
        if (capture_en_o) cnt_cap++;
    end

    // ---------------- driver tasks ----------------
    int bl, bs, bc, bq;

    task automatic mark();
        bl = cnt_load; bs = cnt_shift; bc = cnt_cap; bq = lp_cyc.size();
    endtask

    task automatic idle_cycles(input int n);
        start = 1'b0;
        repeat (n) @(negedge data_clk);
    endtask

    task automatic run_cfg(input logic fr, input logic [7:0] len, input logic [7:0] rep,
                           input logic [NCH-1:0] inv);
        freerun = fr; frame_len = len; repeat_cnt = rep; inv_mask = inv;
        mark();
        start = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge data_clk);
            if (done_o) break;
        end
        if (k == budget) expire(name);
    endtask

    initial begin
        repeat (3) @(negedge data_clk);
        OPB_RST = 1'b0;
        idle_cycles(3);

        // Clean single frame of 8 bits.
        run_cfg(1'b0, 8'd8, 8'd0, '0);
        wait_done("t1_done", 100);
        chk("t1_loads",     32'(cnt_load - bl),  32'd1);
        chk("t1_shifts",    32'(cnt_shift - bs), 32'd8);
        chk("t1_captures",  32'(cnt_cap - bc),   32'd10);
        chk("t1_err_mask",  32'(err_mask_o),     32'h0);
        chk("t1_err_total", 32'(err_total_o),    32'd0);
        idle_cycles(3);

        // Channel 3 returns inverted bits for the whole frame.
        run_cfg(1'b0, 8'd8, 8'd0, 11'h008);
        wait_done("t2_done", 100);
        chk("t2_err_mask",  32'(err_mask_o),  32'h008);
        chk("t2_err_total", 32'(err_total_o), 32'd8);
        inv_mask = '0;
        idle_cycles(3);

        // Three frames of 4 bits.
        run_cfg(1'b0, 8'd4, 8'd2, '0);
        wait_done("t3_done", 200);
        chk("t3_loads",     32'(cnt_load - bl), 32'd3);
        chk("t3_frame_idx", 32'(frame_idx_o),   32'd2);
        if (lp_cyc.size() >= bq + 3) begin
            chk("t3_spacing_a", 32'(lp_cyc[bq+1] - lp_cyc[bq] - 1),   32'd10);
            chk("t3_spacing_b", 32'(lp_cyc[bq+2] - lp_cyc[bq+1] - 1), 32'd10);
            chk("t3_fidx_0",    32'(lp_fidx[bq]),   32'd0);
            chk("t3_fidx_1",    32'(lp_fidx[bq+1]), 32'd1);
            chk("t3_fidx_2",    32'(lp_fidx[bq+2]), 32'd2);
        end
        idle_cycles(3);

        // Abort on the 5th RUN cycle: 3 ch0 compares have happened by then.
        run_cfg(1'b0, 8'd8, 8'd0, 11'h001);
        repeat (6) @(negedge data_clk);
        start = 1'b0;
        @(negedge data_clk);
        chk("t5_busy",      32'(busy_o),       32'd0);
        chk("t5_done",      32'(done_o),       32'd0);
        chk("t5_strobes",   32'({load_pattern_o, clock_en_o, shift_en_o, capture_en_o}), 32'h0);
        chk("t5_err_total", 32'(err_total_o),  32'd3);
        chk("t5_err_mask",  32'(err_mask_o),   32'h001);
        start = 1'b1;
        @(negedge data_clk);
        chk("t5_reload",     32'(load_pattern_o), 32'd1);
        chk("t5_cleared",    32'(err_total_o),    32'd0);
        chk("t5_bits_clear", 32'(bit_count_o),    32'd0);
        inv_mask = '0;
        idle_cycles(3);

        // Asynchronous reset mid-RUN.
        run_cfg(1'b0, 8'd8, 8'd0, 11'h7FF);
        repeat (4) @(negedge data_clk);
        @(posedge data_clk);
        #1;
        chk("t6_pre_total", 32'(err_total_o), 32'd11);
        #2;
        OPB_RST = 1'b1;
        #1;
        chk("t6_rst_strobes", 32'({load_pattern_o, clock_en_o, shift_en_o, capture_en_o}), 32'h0);
        chk("t6_rst_flags",   32'({busy_o, done_o}), 32'h0);
        chk("t6_rst_bits",    32'(bit_count_o), 32'd0);
        chk("t6_rst_fidx",    32'(frame_idx_o), 32'd0);
        chk("t6_rst_mask",    32'(err_mask_o),  32'h0);
        chk("t6_rst_total",   32'(err_total_o), 32'd0);
        start = 1'b0;
        inv_mask = '0;
        repeat (2) @(negedge data_clk);
        OPB_RST = 1'b0;
        repeat (4) @(negedge data_clk);
        chk("t6_idle_busy", 32'(busy_o),         32'd0);
        chk("t6_idle_load", 32'(load_pattern_o), 32'd0);
        start = 1'b1;
        begin : w_t6
            int k;
            for (k = 0; k < 4; k++) begin
                @(negedge data_clk);
                if (load_pattern_o) break;
            end
            if (k == 4) expire("t6_restart_load");
        end
        idle_cycles(3);

        // Freerun, 256-bit frames, every channel mismatching: total saturates.
        run_cfg(1'b1, 8'd0, 8'd0, 11'h7FF);
        begin : w_t4a
            int k;
            for (k = 0; k < 600; k++) begin
                @(negedge data_clk);
                if (cnt_load - bl == 2) break;
            end
            if (k == 600) expire("t4_second_load");
        end
        chk("t4_shifts_per_frame", 32'(cnt_shift - bs), 32'd256);
        begin : w_t4b
            int k;
            for (k = 0; k < 9000; k++) begin
                @(negedge data_clk);
                if (err_total_o == 16'hFFFF) break;
            end
            if (k == 9000) expire("t4_saturate");
        end
        repeat (300) @(negedge data_clk);
        chk("t4_sat_total", 32'(err_total_o), 32'hFFFF);
        chk("t4_sat_mask",  32'(err_mask_o),  32'h7FF);
        chk("t4_no_done",   32'(done_o),      32'd0);
        inv_mask = '0;
        idle_cycles(3);

        // Freerun, 1-bit frames: frame_idx wraps 255 -> 0.
        run_cfg(1'b1, 8'd1, 8'd0, '0);
        begin : w_t7a
            int k;
            for (k = 0; k < 2600; k++) begin
                @(negedge data_clk);
                if (frame_idx_o == 8'd255) break;
            end
            if (k == 2600) expire("t7_reach_255");
        end
        begin : w_t7b
            int k;
            for (k = 0; k < 20; k++) begin
                @(negedge data_clk);
                if (frame_idx_o == 8'd0) break;
            end
            if (k == 20) expire("t7_wrap_to_0");
        end
        chk("t7_loads_at_wrap", 32'(cnt_load - bl), 32'd257);
        chk("t7_no_done",       32'(done_o),        32'd0);
        idle_cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rs485_loopback_sequencer.md
Name: rs485_loopback_sequencer

Overview:
- Sequences the RS485/EnDat/PLIFT loopback test datapath.
- Generates pattern load, shift and capture strobes for N framed bursts.
- Checks every returned bit against the transmitted bit after a fixed loop latency, and accumulates per-channel sticky error flags plus a saturating total error count.
- Sits between the OPB register bank (control fields already synchronized to data_clk) and the pattern/capture shift registers.

Parameters:
- NCH, 11, number of checked loopback channels (width of exp_bits/rx_bits/err_mask).
- LOOP_DLY, 2, data_clk cycles from a TX bit leaving to its RX bit being valid (0..15).
- GAP_CYC, 4, idle data_clk cycles between consecutive frames (1..255).

Ports:
- data_clk  in  1  sequencer clock (divided data clock).
- OPB_RST  in  1  asynchronous, active-high reset.
- start  in  1  level run request, already synchronous to data_clk.
- freerun  in  1  1 = repeat frames indefinitely, ignoring repeat_cnt.
- frame_len  in  8  bits per frame; 0 means 256.
- repeat_cnt  in  8  frames per run minus one.
- exp_bits  in  NCH  bits currently driven on each TX channel.
- rx_bits  in  NCH  bits currently received on each RX channel.
- load_pattern  out  1  one-cycle pulse: reload pattern buffer.
- clock_en  out  1  gates the external data clock outputs.
- shift_en  out  1  advance the TX pattern buffer.
- capture_en  out  1  shift RX bits into the capture registers.
- bit_count  out  9  bits shifted in the current frame.
- frame_idx  out  8  index of the current frame.
- busy  out  1  run in progress.
- done  out  1  run completed normally.
- err_mask  out  NCH  sticky per-channel mismatch flags.
- err_total  out  16  saturating total mismatch count.

Behaviour:
- Reset: state IDLE; every output 0; delay line cleared.
- States: IDLE, LOAD, RUN, DRAIN, GAP, DONE.
- Registered outputs are decoded from the current state.
- IDLE:
  - On start=1, clear err_mask, err_total, frame_idx and bit_count, then go to LOAD.
- LOAD (1 cycle):
  - load_pattern=1, busy=1, bit_count=0. Next state is RUN.
- RUN:
  - clock_en=shift_en=capture_en=busy=1; bit_count increments each cycle.
  - Leave after exactly L cycles, where L = frame_len (0 means 256).
  - Go to DRAIN if LOOP_DLY>0, otherwise go straight to the end-of-frame decision.
- DRAIN (exactly LOOP_DLY cycles):
  - clock_en=capture_en=1, shift_en=0, bit_count holds.
- End-of-frame decision:
  - If freerun=1 or frame_idx<repeat_cnt, go to GAP.
  - Otherwise go to DONE.
- GAP (exactly GAP_CYC cycles):
  - All strobes 0, busy=1.
  - On exit, frame_idx increments (wraps 255 to 0 in freerun) and the state goes to LOAD.
- DONE:
  - done=1, busy=0; results held.
  - Return to IDLE only when start=0.
  - A new run needs start to go low then high again.
- Abort:
  - start=0 in LOAD, RUN, DRAIN or GAP: go to IDLE next cycle; done stays 0.
  - err_mask, err_total and frame_idx hold until the next start.
- Checking:
  - exp_bits plus a valid flag (=shift_en) pass through a LOOP_DLY-deep delay line.
  - mismatch = valid_d & (exp_d ^ rx_bits), evaluated every cycle in RUN and DRAIN.
  - err_mask |= mismatch.
  - err_total += popcount(mismatch), saturating at 16'hFFFF and never wrapping.
  - The delay line is flushed on LOAD, so no cross-frame compare occurs.
- Config sampling: frame_len, repeat_cnt and freerun are sampled every cycle; the team requires software to change them only while busy=0.

Test Plan:
- frame_len=8, repeat_cnt=0, rx_bits=exp_bits delayed 2 cycles, start held high -> load_pattern pulses once, shift_en high 8 cycles, capture_en high 10 cycles, done=1, err_mask=0, err_total=0.
- Same setup with channel 3 rx inverted for the whole frame -> err_mask=11'h008, err_total=8.
- frame_len=4, repeat_cnt=2 -> three load_pattern pulses spaced 4+2+4=10 cycles apart, frame_idx steps 0,1,2, done only after the third frame.
- freerun=1, frame_len=0, all channels always mismatching -> 256 shifts per frame, frame_idx wraps 255 to 0, err_total saturates at 16'hFFFF, done never asserts.
- start dropped on the 5th RUN cycle -> IDLE next cycle, all strobes 0, done=0, err_total preserved; start re-raised -> counters cleared and load_pattern pulses.
- OPB_RST asserted mid-RUN, asynchronous to data_clk -> all outputs 0 immediately; after release the block stays in IDLE until start is seen.
